scratchpad_tile_mover: RTL

- Scratchpad-side initiator for the arbiter's sLoad/sStore protocol. The arbiter is the responder; this block is the requester.
- Accepts tile load/store commands from the tensor-core controller and drives sLoad or sStore with the base address.
- For loads, collects the returned 64-bit rows into a local tile buffer. For stores, sends the buffer out one row per sStore transaction.
- Provides a read port for the systolic array and a write port for the result writeback path.

---
 rtl/scratchpad_tile_mover_if.sv | 42 ++++
 rtl/scratchpad_tile_mover.sv | 125 ++++++++++++
 2 files changed

// File: rtl/scratchpad_tile_mover_if.sv
// Signal bundle for the tile mover: controller command port, tile-buffer access ports and the
// arbiter-facing sLoad/sStore requester port. master = tile mover, slave = its environment.
interface scratchpad_tile_mover_if #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned ROW_W  = 64,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_store;
   logic [ADDR_W-1:0] cmd_addr;
   logic              done;
   logic              err;
   logic [IW-1:0]     rd_row;
   logic [ROW_W-1:0]  rd_data;
   logic              wr_en;
   logic [IW-1:0]     wr_row;
   logic [ROW_W-1:0]  wr_data;
   logic              sLoad;
   logic [ADDR_W-1:0] load_addr;
   logic              sLoad_hit;
   logic [ROW_W-1:0]  load_data;
   logic [2:0]        sLoad_row;
   logic              sStore;
   logic [ADDR_W-1:0] store_addr;
   logic [ROW_W-1:0]  store_data;
   logic              sStore_hit;

   modport master (
      input  cmd_valid, cmd_store, cmd_addr, rd_row, wr_en, wr_row, wr_data,
             sLoad_hit, load_data, sLoad_row, sStore_hit,
      output cmd_ready, done, err, rd_data, sLoad, load_addr, sStore, store_addr, store_data
   );

   modport slave (
      output cmd_valid, cmd_store, cmd_addr, rd_row, wr_en, wr_row, wr_data,
             sLoad_hit, load_data, sLoad_row, sStore_hit,
      input  cmd_ready, done, err, rd_data, sLoad, load_addr, sStore, store_addr, store_data
   );
endinterface

// File: rtl/scratchpad_tile_mover.sv
// Scratchpad-side requester for the arbiter sLoad/sStore protocol: loads a tile burst into a
// local row buffer, or streams the buffer out one row per sStore transaction.
module scratchpad_tile_mover #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned ROW_W      = 64,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned ROW_STRIDE = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input logic                     CLK,
   input logic                     RST,
   scratchpad_tile_mover_if.master bus
);
   localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned RW = $clog2(ROWS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StLoad, StStoreReq, StStoreGap, StDone} state_e;

   state_e            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              err_q, err_d;
   logic              ld_we;
   logic [ROW_W-1:0]  buf_q [ROWS];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         row_q   <= '0;
         tmo_q   <= '0;
         base_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         tmo_q   <= tmo_d;
         base_q  <= base_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      tmo_d         = tmo_q;
      base_d        = base_q;
      err_d         = err_q;
      ld_we         = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.done      = 1'b0;
      bus.sLoad     = 1'b0;
      bus.sStore    = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               base_d  = bus.cmd_addr;
               err_d   = 1'b0;
               row_d   = '0;
               tmo_d   = '0;
               state_d = bus.cmd_store ? StStoreReq : StLoad;
            end
         end
         StLoad: begin
            bus.sLoad = 1'b1;
            if (bus.sLoad_hit) begin
               ld_we = 1'b1;
               row_d = row_q + 1'b1;
               tmo_d = '0;
               if (bus.sLoad_row != 3'(row_q)) err_d = 1'b1;
               // Gate the request on the final hit so the arbiter cannot start a new burst.
               if (row_q == RW'(ROWS - 1)) begin
                  bus.sLoad = 1'b0;
                  state_d   = StDone;
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StStoreReq: begin
            bus.sStore = 1'b1;
            if (bus.sStore_hit) begin
               bus.sStore = 1'b0;
               row_d      = row_q + 1'b1;
               tmo_d      = '0;
               state_d    = StStoreGap;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StStoreGap: begin
            state_d = (row_q < RW'(ROWS)) ? StStoreReq : StDone;
         end
         StDone: begin
            bus.done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A hit that does not belong to the current request is a protocol error.
      if (bus.sLoad_hit && (state_q != StLoad)) err_d = 1'b1;
      if (bus.sStore_hit && (state_q != StStoreReq)) err_d = 1'b1;
   end

   // Load hit is written last so it overrides a same-row port write.
   always_ff @(posedge CLK) begin
      if (bus.wr_en) buf_q[bus.wr_row] <= bus.wr_data;
      if (ld_we) buf_q[row_q[IW-1:0]] <= bus.load_data;
   end

   assign bus.err        = err_q;
   assign bus.load_addr  = base_q;
   assign bus.store_addr = base_q + (ADDR_W'(row_q) * ADDR_W'(ROW_STRIDE));
   assign bus.store_data = (state_q == StStoreReq) ? buf_q[row_q[IW-1:0]] : '0;
   assign bus.rd_data    = buf_q[bus.rd_row];

endmodule
